boson_frame_capture: RTL and testbench

Captures one complete frame from the Boson parallel video bus on request and packs pairs of 16-bit pixels into 32-bit words. The words leave through a valid/ready stream toward the SD/DMA writer. The block sits directly downstream of the `bosonCamera` model/interface, consuming its `vsync`/`hsync`/`valid`/`data` outputs in the frame grabber datapath. It also flags lost data and malformed line timing.

---
 rtl/boson_pkg.sv | 17 +
 rtl/boson_sync_fifo.sv | 45 ++++
 rtl/boson_frame_capture.sv | 176 +++++++++++++++++
 tb/tb_boson_frame_capture.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boson_pkg.sv
// Shared types for the Boson frame grabber: FSM states, default geometry, FIFO word layout.
package boson_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 512;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    CAPTURE,
    FLUSH
  } state_t;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } fifo_word_t;
endpackage

// File: rtl/boson_sync_fifo.sv
// Show-ahead synchronous FIFO; head is visible while !empty, zero-cycle read.
// Writes while full are dropped unless a read frees the slot in the same cycle.
module boson_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd && !empty;
  assign do_wr   = wr && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/boson_frame_capture.sv
// Captures one Boson frame on arm, packs pixel pairs into 32-bit words; pixel-to-FIFO write takes two edges.
// The camera is never stalled: a full FIFO drops words and sets sticky overflow.
module boson_frame_capture
  import boson_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        arm,
  input  logic        cam_vsync,
  input  logic        cam_hsync,
  input  logic        cam_valid,
  input  logic [15:0] cam_data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        line_err
);
  localparam int CW = $clog2(H_ACTIVE);
  localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(V_ACTIVE - 1);

  logic          vs_q, hs_q, vld_q, vs_d, hs_d, vs_rise, hs_rise;
  logic [15:0]   dat_q;
  state_t        state, state_nx;
  logic [CW-1:0] col, col_nx;
  logic [RW-1:0] row, row_nx;
  logic [15:0]   pack_lo, pack_nx;
  logic          sent_pend, pend_nx;
  logic          push, set_lerr, set_ovf, clr_flags;
  logic          can_push, pop, fifo_full, fifo_empty;
  fifo_word_t    push_word, head;

  assign vs_rise   = vs_q & ~vs_d;
  assign hs_rise   = hs_q & ~hs_d;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid & out_ready;
  assign can_push  = !fifo_full || pop;
  assign out_data  = out_valid ? head.data : '0;
  assign out_last  = out_valid & head.last;
  assign busy      = (state != IDLE);
  assign done      = (state == FLUSH) && pop && head.last;

  always_comb begin
    state_nx  = state;
    col_nx    = col;
    row_nx    = row;
    pack_nx   = pack_lo;
    pend_nx   = sent_pend;
    push      = 1'b0;
    push_word = '0;
    set_lerr  = 1'b0;
    set_ovf   = 1'b0;
    clr_flags = 1'b0;
    unique case (state)
      IDLE: if (arm) begin
        state_nx  = WAIT_VS;
        clr_flags = 1'b1;
      end
      WAIT_VS: if (vs_rise) begin
        state_nx = CAPTURE;
        col_nx   = '0;
        row_nx   = '0;
        pack_nx  = '0;
      end
      CAPTURE: begin
        // Timing edges are applied first so a pixel in the same cycle lands on the corrected position.
        if (vs_rise) begin
          set_lerr = 1'b1;
          col_nx   = '0;
          row_nx   = '0;
          pack_nx  = '0;
        end else if (hs_rise && col != '0) begin
          set_lerr = 1'b1;
          col_nx   = '0;
          pack_nx  = '0;
          if (row == ROW_MAX) begin
            state_nx = FLUSH;
            pend_nx  = 1'b1;
          end else begin
            row_nx = row + 1'b1;
          end
        end
        if (vld_q && state_nx == CAPTURE) begin
          if (!col_nx[0]) begin
            pack_nx = dat_q;
          end else begin
            push           = 1'b1;
            push_word.data = {dat_q, pack_nx};
            push_word.last = (col_nx == COL_MAX) && (row_nx == ROW_MAX);
          end
          if (col_nx == COL_MAX) begin
            col_nx = '0;
            if (row_nx == ROW_MAX) state_nx = FLUSH;
            else                   row_nx   = row_nx + 1'b1;
          end else begin
            col_nx = col_nx + 1'b1;
          end
        end
        // A dropped last word is replaced by a sentinel once the FIFO has room.
        if (push && !can_push) begin
          set_ovf = 1'b1;
          if (push_word.last) pend_nx = 1'b1;
        end
      end
      FLUSH: begin
        if (sent_pend && can_push) begin
          push           = 1'b1;
          push_word.last = 1'b1;
          pend_nx        = 1'b0;
        end
        if (pop && head.last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      vld_q     <= 1'b0;
      dat_q     <= '0;
      vs_d      <= 1'b0;
      hs_d      <= 1'b0;
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      pack_lo   <= '0;
      sent_pend <= 1'b0;
      overflow  <= 1'b0;
      line_err  <= 1'b0;
    end else begin
      vs_q      <= cam_vsync;
      hs_q      <= cam_hsync;
      vld_q     <= cam_valid;
      dat_q     <= cam_data;
      vs_d      <= vs_q;
      hs_d      <= hs_q;
      state     <= state_nx;
      col       <= col_nx;
      row       <= row_nx;
      pack_lo   <= pack_nx;
      sent_pend <= pend_nx;
      if (clr_flags) begin
        overflow <= 1'b0;
        line_err <= 1'b0;
      end else begin
        if (set_ovf)  overflow <= 1'b1;
        if (set_lerr) line_err <= 1'b1;
      end
    end
  end

  boson_sync_fifo #(
    .WIDTH($bits(fifo_word_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wr     (push),
    .wr_data(push_word),
    .rd     (pop),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
endmodule

// File: tb/tb_boson_frame_capture.sv
// Bench: instance a is 4x2 pixels, instance b is 8x2 pixels, both with a 4-word FIFO.
// Expected word streams come from a line-buffer model of the packing and timing rules.
module tb_boson_frame_capture;
  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        vld;
    logic [15:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cam_vsync, cam_hsync, cam_valid;
  logic [15:0] cam_data;
  logic        arm_a, out_ready_a, out_valid_a, out_last_a, busy_a, done_a, overflow_a, line_err_a;
  logic [31:0] out_data_a;
  logic        arm_b, out_ready_b, out_valid_b, out_last_b, busy_b, done_b, overflow_b, line_err_b;
  logic [31:0] out_data_b;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt_a = 0;
  int          done_cnt_b = 0;
  beat_t       bq[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_a[$];
  logic [32:0] got_b[$];
  bit          m_err, m_ovf;

  always #5 clk = ~clk;

  boson_frame_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .resetn(resetn), .arm(arm_a),
    .cam_vsync(cam_vsync), .cam_hsync(cam_hsync), .cam_valid(cam_valid), .cam_data(cam_data),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_last(out_last_a),
    .busy(busy_a), .done(done_a), .overflow(overflow_a), .line_err(line_err_a)
  );

  boson_frame_capture #(.H_ACTIVE(8), .V_ACTIVE(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .resetn(resetn), .arm(arm_b),
    .cam_vsync(cam_vsync), .cam_hsync(cam_hsync), .cam_valid(cam_valid), .cam_data(cam_data),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_last(out_last_b),
    .busy(busy_b), .done(done_b), .overflow(overflow_b), .line_err(line_err_b)
  );

  always @(negedge clk) begin
    if (out_valid_a && out_ready_a) got_a.push_back({out_last_a, out_data_a});
    if (out_valid_b && out_ready_b) got_b.push_back({out_last_b, out_data_b});
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chkw(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic beat_t mk(input logic vs, input logic hs, input logic vld, input logic [15:0] d);
    beat_t b;
    b.vs = vs; b.hs = hs; b.vld = vld; b.d = d;
    return b;
  endfunction

  function automatic void add_idle(input int n);
    repeat (n) bq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0));
  endfunction

  function automatic void add_vs();
    bq.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0));
    add_idle(1);
  endfunction

  function automatic void add_hs();
    bq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0));
    add_idle(1);
  endfunction

  function automatic void add_px(input logic [15:0] d, input bit gaps);
    if (gaps) add_idle(int'($urandom_range(0, 1)));
    bq.push_back(mk(1'b0, 1'b0, 1'b1, d));
  endfunction

  function automatic void add_line(input int n);
    for (int i = 0; i < n; i++) add_px(16'($urandom), 1'b1);
  endfunction

  // Reference: collect each line's pixels, emit a word per completed pair; cap models a stalled FIFO.
  function automatic void model(input int h, input int v, input int cap);
    bit          started, fin, pvs, phs, vr, hr, lst;
    int          rows;
    logic [15:0] line[$];
    started = 0; fin = 0; pvs = 0; phs = 0; rows = 0;
    exp_q.delete();
    m_err = 0;
    m_ovf = 0;
    foreach (bq[i]) begin
      vr  = bq[i].vs && !pvs;
      hr  = bq[i].hs && !phs;
      pvs = bq[i].vs;
      phs = bq[i].hs;
      if (fin) continue;
      if (!started) begin
        if (vr) started = 1;
        continue;
      end
      if (vr) begin
        m_err = 1; rows = 0; line.delete();
      end else if (hr && line.size() != 0) begin
        m_err = 1; line.delete(); rows++;
        if (rows == v) begin
          fin = 1;
          exp_q.push_back({1'b1, 32'h0});
          continue;
        end
      end
      if (bq[i].vld) begin
        line.push_back(bq[i].d);
        if (line.size() % 2 == 0) begin
          lst = (line.size() == h) && (rows == v - 1);
          if (exp_q.size() < cap) begin
            exp_q.push_back({lst, line[line.size()-1], line[line.size()-2]});
          end else begin
            m_ovf = 1;
            if (lst) exp_q.push_back({1'b1, 32'h0});
          end
        end
        if (line.size() == h) begin
          line.delete();
          rows++;
          if (rows == v) fin = 1;
        end
      end
    end
  endfunction

  task automatic play();
    foreach (bq[i]) begin
      cam_vsync = bq[i].vs;
      cam_hsync = bq[i].hs;
      cam_valid = bq[i].vld;
      cam_data  = bq[i].d;
      cyc(1);
    end
    cam_vsync = 1'b0; cam_hsync = 1'b0; cam_valid = 1'b0; cam_data = 16'h0;
    bq.delete();
  endtask

  task automatic pulse_arm(input bit sel, input string tag);
    if (sel) arm_b = 1'b1;
    else     arm_a = 1'b1;
    cyc(1);
    arm_a = 1'b0;
    arm_b = 1'b0;
    chk1({tag, " busy_after_arm"}, sel ? busy_b : busy_a, 1'b1);
  endtask

  task automatic wait_done(input bit sel, input string tag);
    int n;
    n = 0;
    while (!(sel ? done_b : done_a) && n < 400) begin
      cyc(1);
      n++;
    end
    chk1({tag, " done_seen"}, sel ? done_b : done_a, 1'b1);
    cyc(1);
    chk1({tag, " busy_fall"}, sel ? busy_b : busy_a, 1'b0);
  endtask

  task automatic cmp_stream(input string tag, input bit sel);
    int n_got;
    n_got = sel ? got_b.size() : got_a.size();
    chkw({tag, " word_count"}, 33'(n_got), 33'(exp_q.size()));
    foreach (exp_q[i])
      if (i < n_got) chkw($sformatf("%s word%0d", tag, i), sel ? got_b[i] : got_a[i], exp_q[i]);
    got_a.delete();
    got_b.delete();
  endtask

  task automatic run_ready_frame(input string tag);
    int dc0;
    dc0 = done_cnt_a;
    model(4, 2, 1000);
    play();
    wait_done(1'b0, tag);
    cyc(2);
    cmp_stream(tag, 1'b0);
    chkw({tag, " done_once"}, 33'(done_cnt_a - dc0), 33'd1);
    chk1({tag, " line_err"}, line_err_a, m_err);
    chk1({tag, " overflow"}, overflow_a, m_ovf);
  endtask

  initial begin
    int dc0;
    resetn = 1'b0;
    arm_a = 1'b0; arm_b = 1'b0; out_ready_a = 1'b0; out_ready_b = 1'b0;
    cam_vsync = 1'b0; cam_hsync = 1'b0; cam_valid = 1'b0; cam_data = 16'h0;
    cyc(3);
    chk1("reset out_valid", out_valid_a, 1'b0);
    chk1("reset out_last", out_last_a, 1'b0);
    chkw("reset out_data", {1'b0, out_data_a}, 33'h0);
    chk1("reset busy", busy_a, 1'b0);
    chk1("reset done", done_a, 1'b0);
    chk1("reset overflow", overflow_a, 1'b0);
    chk1("reset line_err", line_err_a, 1'b0);
    chk1("reset b busy", busy_b, 1'b0);
    resetn = 1'b1;
    cyc(2);

    // Nominal frame with fixed pixels 1..8
    out_ready_a = 1'b1;
    pulse_arm(1'b0, "nominal");
    dc0 = done_cnt_a;
    add_idle(2); add_vs(); add_hs();
    for (int i = 1; i <= 4; i++) add_px(16'(i), 1'b0);
    add_hs();
    for (int i = 5; i <= 8; i++) add_px(16'(i), 1'b0);
    play();
    exp_q = '{33'h0_0002_0001, 33'h0_0004_0003, 33'h0_0006_0005, 33'h1_0008_0007};
    wait_done(1'b0, "nominal");
    cyc(3);
    cmp_stream("nominal", 1'b0);
    chkw("nominal done_once", 33'(done_cnt_a - dc0), 33'd1);
    chk1("nominal line_err", line_err_a, 1'b0);
    chk1("nominal overflow", overflow_a, 1'b0);

    // Backpressure for the whole frame
    out_ready_a = 1'b0;
    pulse_arm(1'b0, "bp");
    dc0 = done_cnt_a;
    add_idle(1); add_vs(); add_hs(); add_line(4); add_hs(); add_line(4);
    model(4, 2, 4);
    play();
    cyc(6);
    chk1("bp out_valid", out_valid_a, 1'b1);
    chk1("bp overflow", overflow_a, 1'b0);
    chkw("bp head", {out_last_a, out_data_a}, exp_q[0]);
    cyc(5);
    chkw("bp head_stable", {out_last_a, out_data_a}, exp_q[0]);
    chkw("bp no_done", 33'(done_cnt_a - dc0), 33'd0);
    out_ready_a = 1'b1;
    wait_done(1'b0, "bp");
    cyc(2);
    cmp_stream("bp", 1'b0);

    // Overflow on the 8-wide instance
    pulse_arm(1'b1, "ovf");
    add_idle(1); add_vs(); add_hs(); add_line(8); add_hs(); add_line(8);
    model(8, 2, 4);
    play();
    cyc(6);
    chk1("ovf overflow", overflow_b, m_ovf);
    chk1("ovf out_valid", out_valid_b, 1'b1);
    chk1("ovf busy", busy_b, 1'b1);
    out_ready_b = 1'b1;
    wait_done(1'b1, "ovf");
    cyc(2);
    cmp_stream("ovf", 1'b1);
    chk1("ovf overflow_sticky", overflow_b, 1'b1);
    out_ready_b = 1'b0;

    // Short first line
    pulse_arm(1'b0, "short");
    add_idle(1); add_vs(); add_hs(); add_line(2); add_hs(); add_line(4);
    run_ready_frame("short");

    // Short final line: sentinel terminates the frame
    pulse_arm(1'b0, "shortlast");
    add_idle(1); add_vs(); add_hs(); add_line(4); add_hs(); add_line(2); add_hs();
    run_ready_frame("shortlast");

    // Premature vsync in row 1
    pulse_arm(1'b0, "prevs");
    add_idle(1); add_vs(); add_hs(); add_line(4); add_hs(); add_line(2);
    add_vs(); add_hs(); add_line(4); add_hs(); add_line(4);
    run_ready_frame("prevs");

    // Reset mid-frame
    out_ready_a = 1'b0;
    pulse_arm(1'b0, "rstmid");
    dc0 = done_cnt_a;
    add_idle(1); add_vs(); add_hs(); add_line(3);
    play();
    cyc(4);
    chk1("rstmid queued", out_valid_a, 1'b1);
    resetn = 1'b0;
    #1;
    chk1("rstmid out_valid", out_valid_a, 1'b0);
    chk1("rstmid out_last", out_last_a, 1'b0);
    chkw("rstmid out_data", {1'b0, out_data_a}, 33'h0);
    chk1("rstmid busy", busy_a, 1'b0);
    chk1("rstmid done", done_a, 1'b0);
    chk1("rstmid line_err", line_err_a, 1'b0);
    cyc(2);
    resetn = 1'b1;
    cyc(2);
    chk1("rstmid idle_valid", out_valid_a, 1'b0);
    chkw("rstmid no_done", 33'(done_cnt_a - dc0), 33'd0);
    got_a.delete();
    out_ready_a = 1'b1;
    pulse_arm(1'b0, "clean");
    add_idle(1); add_vs(); add_hs(); add_line(4); add_hs(); add_line(4);
    run_ready_frame("clean");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
